// File: rtl/tff_chain.sv
// tff_chain: a row of STAGES toggle flops with four behaviours.
// The behaviours are a rippling toggle chain, an up counter, a down counter
// and a freeze. The block also has a terminal-count pulse, a sticky wrap flag,
// a parallel load and an asynchronous active-low reset.
module tff_chain #(
   parameter int STAGES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic              load,
   input  logic [STAGES-1:0] load_val,
   output logic [STAGES-1:0] q,
   output logic              tc,
   output logic              ovf
);

   localparam logic [1:0] MODE_CHAIN  = 2'd0;
   localparam logic [1:0] MODE_UP     = 2'd1;
   localparam logic [1:0] MODE_DOWN   = 2'd2;
   localparam logic [1:0] MODE_FREEZE = 2'd3;

   // Chain: stage 0 follows the request, and each later stage follows the
   // pre-edge value of the stage before it. Propagation is one stage per edge.
   function automatic logic [STAGES-1:0] chain_mask(input logic [STAGES-1:0] v,
                                                    input logic d);
      logic [STAGES-1:0] m;
      m[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         m[i] = v[i-1];
      end
      return m;
   endfunction

   // Up count: stage i toggles when every lower stage is one.
   function automatic logic [STAGES-1:0] up_mask(input logic [STAGES-1:0] v);
      logic [STAGES-1:0] m;
      logic              carry;
      carry = 1'b1;
      for (int i = 0; i < STAGES; i++) begin
         m[i]  = carry;
         carry = carry & v[i];
      end
      return m;
   endfunction

   // Down count: stage i toggles when every lower stage is zero.
   function automatic logic [STAGES-1:0] down_mask(input logic [STAGES-1:0] v);
      logic [STAGES-1:0] m;
      logic              borrow;
      borrow = 1'b1;
      for (int i = 0; i < STAGES; i++) begin
         m[i]   = borrow;
         borrow = borrow & ~v[i];
      end
      return m;
   endfunction

   logic [STAGES-1:0] toggle;
   logic              wrap;

   // Work out which stages toggle on this edge, and whether the count wraps.
   always_comb begin
      toggle = '0;
      wrap   = 1'b0;
      case (mode)
         MODE_CHAIN: toggle = chain_mask(q, data);
         MODE_UP: begin
            if (data) begin
               toggle = up_mask(q);
               wrap   = &q;
            end
         end
         MODE_DOWN: begin
            if (data) begin
               toggle = down_mask(q);
               wrap   = ~|q;
            end
         end
         default: toggle = '0;
      endcase
   end

   // State update, in priority order: reset, load, enable, then the mode action.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q   <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else if (load) begin
         q   <= load_val;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else if (en) begin
         q <= q ^ toggle;
         case (mode)
            MODE_UP, MODE_DOWN: begin
               tc <= wrap;
               if (wrap) ovf <= 1'b1;
            end
            MODE_FREEZE: tc <= 1'b0;
            default:     tc <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_tff_chain.sv
// Directed bench for tff_chain with STAGES=4.
module tb_tff_chain;

   logic       clk;
   logic       rst;
   logic       data;
   logic       en;
   logic [1:0] mode;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       tc;
   logic       ovf;

   int total;
   int bad;

   tff_chain #(.STAGES(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .data     (data),
      .en       (en),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .tc       (tc),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({q, tc, ovf} !== 6'b0000_0_0) begin
         bad++;
         $display("FAIL reset_state got q=%b tc=%b ovf=%b want q=0000 tc=0 ovf=0", q, tc, ovf);
      end
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0000_0_0) begin
         bad++;
         $display("FAIL reset_held_edge got q=%b tc=%b ovf=%b want 0000 0 0", q, tc, ovf);
      end
      rst = 1'b1;
   endtask

   task automatic test_chain();
      logic [3:0] exp_q [4];
      exp_q[0] = 4'b0001; exp_q[1] = 4'b0010; exp_q[2] = 4'b0111; exp_q[3] = 4'b1001;
      mode = 2'd0; en = 1'b1; data = 1'b1; load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) data = 1'b0;
         step();
         total++;
         if ({q, tc, ovf} !== {exp_q[i], 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL chain_edge%0d got q=%b tc=%b ovf=%b want q=%b tc=0 ovf=0",
                     i, q, tc, ovf, exp_q[i]);
         end
      end
   endtask

   task automatic test_up_wrap();
      mode = 2'd1; data = 1'b0; load = 1'b1; load_val = 4'b1110;
      step();
      load = 1'b0; data = 1'b1;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b1111_0_0) begin
         bad++;
         $display("FAIL up_to_ones got q=%b tc=%b ovf=%b want 1111 0 0", q, tc, ovf);
      end
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0000_1_1) begin
         bad++;
         $display("FAIL up_wrap got q=%b tc=%b ovf=%b want 0000 1 1", q, tc, ovf);
      end
      data = 1'b0;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0000_0_1) begin
         bad++;
         $display("FAIL up_after_wrap got q=%b tc=%b ovf=%b want 0000 0 1", q, tc, ovf);
      end
      mode = 2'd0;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0000_0_1) begin
         bad++;
         $display("FAIL chain_ovf_hold got q=%b tc=%b ovf=%b want 0000 0 1", q, tc, ovf);
      end
   endtask

   task automatic test_down_wrap_load();
      mode = 2'd2; data = 1'b0; load = 1'b1; load_val = 4'b0001;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0001_0_0) begin
         bad++;
         $display("FAIL down_load got q=%b tc=%b ovf=%b want 0001 0 0", q, tc, ovf);
      end
      load = 1'b0; data = 1'b1;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0000_0_0) begin
         bad++;
         $display("FAIL down_to_zero got q=%b tc=%b ovf=%b want 0000 0 0", q, tc, ovf);
      end
      step();
      total++;
      if ({q, tc, ovf} !== 6'b1111_1_1) begin
         bad++;
         $display("FAIL down_wrap got q=%b tc=%b ovf=%b want 1111 1 1", q, tc, ovf);
      end
      data = 1'b0; load = 1'b1; load_val = 4'b0101;
      step();
      load = 1'b0;
      total++;
      if ({q, tc, ovf} !== 6'b0101_0_0) begin
         bad++;
         $display("FAIL down_reload got q=%b tc=%b ovf=%b want 0101 0 0", q, tc, ovf);
      end
   endtask

   task automatic test_enable_freeze();
      mode = 2'd1; load = 1'b1; load_val = 4'b0011; data = 1'b0;
      step();
      load = 1'b0; en = 1'b0; data = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({q, tc, ovf} !== 6'b0011_0_0) begin
            bad++;
            $display("FAIL en_low_hold%0d got q=%b tc=%b ovf=%b want 0011 0 0", i, q, tc, ovf);
         end
      end
      en = 1'b1;
      step();
      total++;
      if (q !== 4'b0100) begin
         bad++;
         $display("FAIL en_resume got q=%b want 0100", q);
      end
      mode = 2'd3;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0100_0_0) begin
         bad++;
         $display("FAIL freeze_hold got q=%b tc=%b ovf=%b want 0100 0 0", q, tc, ovf);
      end
      // tc freezes with en low; freeze mode clears it.
      mode = 2'd1; load = 1'b1; load_val = 4'b1111;
      step();
      load = 1'b0;
      step();
      en = 1'b0;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0000_1_1) begin
         bad++;
         $display("FAIL en_low_tc_hold got q=%b tc=%b ovf=%b want 0000 1 1", q, tc, ovf);
      end
      en = 1'b1; mode = 2'd3;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0000_0_1) begin
         bad++;
         $display("FAIL freeze_tc_clear got q=%b tc=%b ovf=%b want 0000 0 1", q, tc, ovf);
      end
   endtask

   task automatic test_load_en_low();
      en = 1'b0; mode = 2'd1; data = 1'b1; load = 1'b1; load_val = 4'b1010;
      step();
      load = 1'b0; en = 1'b1;
      total++;
      if ({q, tc, ovf} !== 6'b1010_0_0) begin
         bad++;
         $display("FAIL load_en_low got q=%b tc=%b ovf=%b want 1010 0 0", q, tc, ovf);
      end
      mode = 2'd2; data = 1'b0;
      step();
      total++;
      if (q !== 4'b1010) begin
         bad++;
         $display("FAIL mode_change_keep got q=%b want 1010", q);
      end
      data = 1'b1;
      step();
      total++;
      if (q !== 4'b1001) begin
         bad++;
         $display("FAIL mode_change_down got q=%b want 1001", q);
      end
   endtask

   task automatic test_async_reset();
      mode = 2'd1; data = 1'b0; load = 1'b1; load_val = 4'b1111;
      step();
      load = 1'b0; data = 1'b1;
      for (int i = 0; i < 7; i++) step();
      total++;
      if ({q, tc, ovf} !== 6'b0110_0_1) begin
         bad++;
         $display("FAIL pre_reset_count got q=%b tc=%b ovf=%b want 0110 0 1", q, tc, ovf);
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({q, tc, ovf} !== 6'b0000_0_0) begin
         bad++;
         $display("FAIL async_reset got q=%b tc=%b ovf=%b want 0000 0 0", q, tc, ovf);
      end
      load = 1'b1; load_val = 4'b1011;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0000_0_0) begin
         bad++;
         $display("FAIL reset_ignores_load got q=%b tc=%b ovf=%b want 0000 0 0", q, tc, ovf);
      end
      load = 1'b0;
      rst = 1'b1;
      step();
      total++;
      if ({q, tc, ovf} !== 6'b0001_0_0) begin
         bad++;
         $display("FAIL post_reset_count got q=%b tc=%b ovf=%b want 0001 0 0", q, tc, ovf);
      end
   endtask

   task automatic test_back_to_back();
      int         pulses;
      logic [3:0] exp_q;
      pulses = 0;
      exp_q  = 4'b0000;
      mode = 2'd1; data = 1'b0; load = 1'b1; load_val = 4'b0000;
      step();
      load = 1'b0; data = 1'b1;
      for (int i = 0; i < 32; i++) begin
         step();
         exp_q = exp_q + 4'd1;
         if (tc) pulses++;
         total++;
         if ({q, tc} !== {exp_q, (exp_q == 4'b0000)}) begin
            bad++;
            $display("FAIL run_edge%0d got q=%b tc=%b want q=%b tc=%b",
                     i, q, tc, exp_q, (exp_q == 4'b0000));
         end
      end
      total++;
      if (pulses != 2) begin
         bad++;
         $display("FAIL run_tc_count got %0d want 2", pulses);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b0; data = 1'b0; en = 1'b0; mode = 2'd0; load = 1'b0; load_val = 4'b0000;
      test_reset();
      test_chain();
      test_up_wrap();
      test_down_wrap_load();
      test_enable_freeze();
      test_load_en_low();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
